obi_mem_responder: RTL and testbench
====================================

// Module: obi_mem_responder
// PURPOSE
//   Memory-side responder for the core's req/gnt/rvalid instruction and data bus.
//   Accepts one request per cycle and services it from an internal word array.
//   Returns each response a fixed number of cycles after its grant.
//   Serves as the memory behind a core instr/data port, in the SoC and in core-level benches.
// PARAMETERS
//   NumWords  1024          words of storage; power of two, >= 2
//   Latency   1             grant-to-rvalid delay in cycles; legal 1..4, elaboration assert otherwise
//   BaseAddr  32'h1000_0000 byte address of word 0; 4*NumWords-aligned
// PORTS
//   clk_i    in   1   clock
//   rst_i    in   1   synchronous reset, active-high
//   req_i    in   1   request valid
//   gnt_o    out  1   request accepted this cycle
//   we_i     in   1   1 = write, 0 = read
//   be_i     in   4   write byte enables; ignored for reads
//   addr_i   in   32  byte address; bits [1:0] ignored
//   wdata_i  in   32  write data
//   rvalid_o out  1   response valid, exactly one per granted request
//   rdata_o  out  32  read data; 0 for write responses and error responses
//   err_o    out  1   response error; qualified by rvalid_o
// BEHAVIOUR
//   - Reset (rst_i=1 at a clock edge): rvalid_o=0, rdata_o=0, err_o=0, all pipeline stages cleared.
//     gnt_o=0 while rst_i=1. Array contents are not reset.
//   - Grant: gnt_o = req_i & ~rst_i, combinational, with no back-pressure.
//     Granted request at edge t -> rvalid_o=1 during cycle t+Latency, for one cycle.
//   - Response order equals request order. Back-to-back requests give back-to-back rvalid.
//   - Index: idx = addr_i[2 +: $clog2(NumWords)], i.e. a word offset relative to BaseAddr.
//   - Write: bytes with be_i[b]=1 are updated at the grant edge.
//     be_i=4'b0000 is a legal no-op write that still gets a response.
//   - Read: the array is sampled at the grant edge and carried through Latency-1 further stages.
//     A read granted at t+1 after a write granted at t returns the new data.
//   - Reset mid-operation: in-flight responses are discarded and never appear on rvalid_o.
//     A write granted before the reset edge is kept in the array.
//   - Pipeline stage content = {valid, err, rdata}. Stage 0 is loaded at the grant edge.
//     The last stage drives rvalid_o, err_o and rdata_o directly from flops.
// CONFIGURATION
//   OBI_RSP_ERR_EN defined:
//     - A request is in range when (addr_i - BaseAddr) < 4*NumWords, compared unsigned over 32 bits.
//     - Out-of-range request: still granted; array untouched; response has err_o=1 and rdata_o=0.
//   OBI_RSP_ERR_EN undefined:
//     - No range check; addresses alias modulo 4*NumWords.
//     - err_o is constant 0; no comparator is synthesised.
// STRUCTURE
//   - Shared package obi_rsp_pkg holds:
//     - typedef obi_rsp_t {logic valid; logic err; logic [31:0] rdata;}
//     - localparam MaxLatency = 4
//   - Sub-module obi_rsp_pipe #(Latency): shift register of obi_rsp_t with sync clear.
//     It is instantiated once; array and address decode stay in obi_mem_responder.
// TESTING
//   1. Write 0xDEADBEEF, be=F, to BaseAddr+0x10, then read it back; Latency=1.
//      -> Write response: rvalid one cycle after grant, rdata=0, err=0.
//      -> Read response: rvalid one cycle after grant, rdata=0xDEADBEEF.
//   2. Word holds 0xDEADBEEF; write 0x11223344 with be=4'b0101; read back.
//      -> rdata=0xDE22BE44.
//   3. Latency=3: 4 back-to-back reads of words 0..3, preloaded with 0xA0..0xA3.
//      -> rvalid high for 4 consecutive cycles starting 3 cycles after the first grant.
//      -> Data 0xA0..0xA3 in order.
//   4. Write 0x5 to word 7 at cycle t; read word 7 at cycle t+1.
//      -> rdata=0x5; no stale data.
//   5. OBI_RSP_ERR_EN defined: write 0xFFFF_FFFF to BaseAddr+4*NumWords, then read word 0.
//      -> Write response: err=1, rdata=0.
//      -> Read of word 0 returns its prior value.
//      -> Read of BaseAddr-4: err=1.
//   6. Latency=2: grant 2 reads, then assert rst_i on the next edge.
//      -> No rvalid ever appears for those reads; outputs are 0 the cycle after reset.
//      -> gnt_o=0 while rst_i=1.

Source files
------------

// File: rtl/obi_rsp_pkg.sv
// Shared types and limits for the OBI memory responder and its response pipeline.
package obi_rsp_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } obi_rsp_t;

  localparam int MaxLatency = 4;

endpackage

// File: rtl/obi_rsp_pipe.sv
// Fixed-depth shift register of responses; stage 0 loads at the grant edge and the
// last stage drives the bus outputs straight from flops.
module obi_rsp_pipe
  import obi_rsp_pkg::*;
#(
  parameter int Latency = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid,
  input  logic        in_err,
  input  logic [31:0] in_rdata,
  output logic        out_valid,
  output logic        out_err,
  output logic [31:0] out_rdata
);

  obi_rsp_t stage_q [Latency];

  // A synchronous clear drops every in-flight response, so none of them can surface after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Latency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= '{valid: in_valid, err: in_err, rdata: in_rdata};
      for (int i = 1; i < Latency; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign out_valid = stage_q[Latency-1].valid;
  assign out_err   = stage_q[Latency-1].err;
  assign out_rdata = stage_q[Latency-1].rdata;

endmodule

// File: rtl/obi_mem_responder.sv
// Memory-side OBI responder: word array with byte-enabled writes and fixed-latency responses.
// Optional feature: define OBI_RSP_ERR_EN to flag out-of-range addresses with err_o.
module obi_mem_responder
  import obi_rsp_pkg::*;
#(
  parameter int          NumWords = 1024,
  parameter int          Latency  = 1,
  parameter logic [31:0] BaseAddr = 32'h1000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int IdxW = $clog2(NumWords);

  if (Latency < 1 || Latency > MaxLatency) begin : g_bad_latency
    $error("obi_mem_responder: Latency must be within 1..%0d", MaxLatency);
  end
  if (NumWords < 2 || (NumWords & (NumWords - 1)) != 0) begin : g_bad_words
    $error("obi_mem_responder: NumWords must be a power of two >= 2");
  end

  logic [31:0]     mem [NumWords];
  logic [IdxW-1:0] idx;
  logic            gnt;
  logic            in_range;
  logic            unused_addr;
  logic            rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;

  assign gnt   = req_i & ~rst_i;
  assign gnt_o = gnt;
  assign idx   = addr_i[2 +: IdxW];

  // Low address bits and the base are consumed only by the optional range check.
  assign unused_addr = ^{addr_i, BaseAddr};

`ifdef OBI_RSP_ERR_EN
  logic [31:0] offset;
  assign offset   = addr_i - BaseAddr;
  assign in_range = offset < 32'(4 * NumWords);
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (gnt && we_i && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Writes and error responses carry zero data; only in-range reads sample the array.
  always_comb begin
    rsp_valid = gnt;
    rsp_err   = gnt & ~in_range;
    rsp_rdata = '0;
    if (gnt && !we_i && in_range) begin
      rsp_rdata = mem[idx];
    end
  end

  obi_rsp_pipe #(
    .Latency (Latency)
  ) u_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (rsp_valid),
    .in_err    (rsp_err),
    .in_rdata  (rsp_rdata),
    .out_valid (rvalid_o),
    .out_err   (err_o),
    .out_rdata (rdata_o)
  );

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed table bench driving one shared stimulus into responders of Latency 1, 2 and 3.
// Each table row carries the hand-computed response expected for that request.
module tb_obi_mem_responder;

  localparam int          NumWords = 64;
  localparam logic [31:0] Base     = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  gnt;
  logic [2:0]  rvalid;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    obi_mem_responder #(
      .NumWords (NumWords),
      .Latency  (k + 1),
      .BaseAddr (Base)
    ) u_dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req),
      .gnt_o    (gnt[k]),
      .we_i     (we),
      .be_i     (be),
      .addr_i   (addr),
      .wdata_i  (wdata),
      .rvalid_o (rvalid[k]),
      .rdata_o  (rdata[k]),
      .err_o    (err[k])
    );
  end

  typedef struct {
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic q, input logic w, input logic [3:0] b,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic ev, input logic ee, input logic [31:0] ed);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.be = b; v.addr = a; v.wdata = d;
    v.ev = ev; v.ee = ee; v.ed = ed;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst   = v.rst;
    req   = v.req;
    we    = v.we;
    be    = v.be;
    addr  = v.addr;
    wdata = v.wdata;
  endtask

  initial begin
    vec_t v;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_data;
    bit          flushed;

    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;

    // rst req we be addr wdata | expected valid err rdata (for the Latency=1 view)
    add(1, 1, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(1, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'h10, 32'hDEADBEEF, 1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h10, 32'h0,        1, 0, 32'hDEADBEEF);
    add(0, 1, 1, 4'h5, Base + 32'h10, 32'h11223344, 1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h10, 32'h0,        1, 0, 32'hDE22BE44);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'h0,  32'hA0,       1, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'h4,  32'hA1,       1, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'h8,  32'hA2,       1, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'hC,  32'hA3,       1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h0,  32'h0,        1, 0, 32'hA0);
    add(0, 1, 0, 4'h0, Base + 32'h4,  32'h0,        1, 0, 32'hA1);
    add(0, 1, 0, 4'h0, Base + 32'h8,  32'h0,        1, 0, 32'hA2);
    add(0, 1, 0, 4'h0, Base + 32'hC,  32'h0,        1, 0, 32'hA3);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 1, 1, 4'hF, Base + 32'h1C, 32'h5,        1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h1C, 32'h0,        1, 0, 32'h5);
    add(0, 1, 1, 4'h0, Base + 32'h1C, 32'h0,        1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h1C, 32'h0,        1, 0, 32'h5);
`ifdef OBI_RSP_ERR_EN
    add(0, 1, 1, 4'hF, Base + 32'h100, 32'hFFFFFFFF, 1, 1, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h0,   32'h0,        1, 0, 32'hA0);
    add(0, 1, 0, 4'h0, Base - 32'h4,   32'h0,        1, 1, 32'h0);
`else
    add(0, 1, 1, 4'hF, Base + 32'h100, 32'hFFFFFFFF, 1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h0,   32'h0,        1, 0, 32'hFFFFFFFF);
    add(0, 1, 0, 4'h0, Base + 32'h104, 32'h0,        1, 0, 32'hA1);
`endif
    add(0, 1, 0, 4'h0, Base + 32'h4,  32'h0,        1, 0, 32'hA1);
    add(0, 1, 1, 4'hF, Base + 32'h14, 32'h77,       1, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h14, 32'h0,        1, 0, 32'h77);
    add(1, 1, 0, 4'h0, Base + 32'h14, 32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 1, 0, 4'h0, Base + 32'h14, 32'h0,        1, 0, 32'h77);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);
    add(0, 0, 0, 4'h0, Base,          32'h0,        0, 0, 32'h0);

    @(negedge clk);
    for (int n = 0; n < vecs.size(); n++) begin
      applyStimulus(vecs[n]);
      #1;
      for (int k = 0; k < 3; k++) begin
        checkOutput($sformatf("s%0d L%0d gnt", n, k + 1), 32'(gnt[k]),
                    32'(vecs[n].req & ~vecs[n].rst));
      end
      @(posedge clk);
      @(negedge clk);
      // Latency L shows the response of the request issued L-1 steps ago,
      // unless a reset edge fell in between and flushed it.
      for (int k = 0; k < 3; k++) begin
        e_valid = 1'b0; e_err = 1'b0; e_data = '0;
        if (n - k >= 0) begin
          flushed = 1'b0;
          for (int j = n - k; j <= n; j++) begin
            if (vecs[j].rst) flushed = 1'b1;
          end
          if (!flushed) begin
            e_valid = vecs[n-k].ev;
            e_err   = vecs[n-k].ee;
            e_data  = vecs[n-k].ed;
          end
        end
        checkOutput($sformatf("s%0d L%0d rvalid", n, k + 1), 32'(rvalid[k]), 32'(e_valid));
        checkOutput($sformatf("s%0d L%0d err", n, k + 1),    32'(err[k]),    32'(e_err));
        checkOutput($sformatf("s%0d L%0d rdata", n, k + 1),  rdata[k],       e_data);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
